// File: rtl/bit_vector_adder_pipelined.sv
// bit_vector_adder_pipelined
//   Pipelined population count of a VECTOR_SIZE-bit vector, with an optional
//   per-packet accumulate mode that saturates at 2^ACC_WIDTH-1.
//
//   The vector is zero-padded to P = 2^clog2(VECTOR_SIZE) leaves and reduced by
//   an L = clog2(P) level binary adder tree. The leaves are registered on
//   acceptance (stage 0); after that a register is placed every REG_EVERY
//   levels and always after the root, giving T = ceil(L/REG_EVERY) tree stages.
//   One more stage forms the output / accumulator. Latency is T+1 edges from
//   the accepting edge.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   acc_mode            0 = count, 1 = accumulate (travels with its beat)
//   s_valid/s_ready     input handshake, s_data vector, s_last end of packet
//   m_valid/m_ready     output handshake
//   m_sum               popcount or saturated packet total
//   m_overflow          packet total saturated (accumulate mode only)
module bit_vector_adder_pipelined #(
  parameter int VECTOR_SIZE = 16,
  parameter int REG_EVERY   = 1,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   acc_mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [VECTOR_SIZE-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ACC_WIDTH-1:0]   m_sum,
  output logic                   m_overflow
);

  // Guarded so that an illegal parameter set still elaborates far enough for
  // the check below to report it.
  localparam int L   = (VECTOR_SIZE < 2) ? 1 : $clog2(VECTOR_SIZE);
  localparam int P   = 1 << L;
  localparam int RE  = (REG_EVERY < 1) ? 1 : REG_EVERY;
  localparam int T   = (L + RE - 1) / RE;
  // Every tree node is carried at root width; the bits above n+1 at level n
  // are constant zero and get trimmed by synthesis.
  localparam int SW  = L + 1;
  localparam int AW1 = ACC_WIDTH + 1;

  generate
    if (VECTOR_SIZE < 2 || REG_EVERY < 1 || ACC_WIDTH < $clog2(VECTOR_SIZE) + 1) begin : g_param_check
      $error("bit_vector_adder_pipelined: illegal parameters VECTOR_SIZE=%0d REG_EVERY=%0d ACC_WIDTH=%0d",
             VECTOR_SIZE, REG_EVERY, ACC_WIDTH);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Flow control: one global enable. Nothing moves while the output is stalled.
  // ---------------------------------------------------------------------------
  logic adv;
  logic accept;
  logic ready_q, ready_d;

  assign adv     = !m_valid || m_ready;
  // ready_q keeps s_ready low until the first edge after reset is released.
  assign s_ready = adv && ready_q;
  assign accept  = s_valid && s_ready;

  logic [P-1:0] data_pad;
  assign data_pad = P'(s_data);

  // ---------------------------------------------------------------------------
  // Adder tree. Level gi has P>>gi nodes. node_d is the combinational value of
  // the level, node_out is what the next level consumes (registered copy on
  // stage boundaries, node_d otherwise).
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi <= L; gi++) begin : g_lvl
      localparam int N = P >> gi;
      logic [SW-1:0] node_d   [N];
      logic [SW-1:0] node_out [N];

      if (gi == 0) begin : g_leaf
        always_comb begin
          for (int i = 0; i < N; i++) begin
            node_d[i] = SW'(data_pad[i]);
          end
        end
      end else begin : g_add
        always_comb begin
          for (int i = 0; i < N; i++) begin
            node_d[i] = g_lvl[gi-1].node_out[2*i] + g_lvl[gi-1].node_out[2*i+1];
          end
        end
      end

      if ((gi % RE == 0) || (gi == L)) begin : g_reg
        logic [SW-1:0] node_q [N];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
              node_q[i] <= '0;
            end
          end else if (adv) begin
            node_q <= node_d;
          end
        end
        assign node_out = node_q;
      end else begin : g_comb
        assign node_out = node_d;
      end
    end
  endgenerate

  logic [SW-1:0] count;
  assign count = g_lvl[L].node_out[0];

  // ---------------------------------------------------------------------------
  // Per-stage side-band: valid, mode and last, stages 0..T.
  // ---------------------------------------------------------------------------
  logic [T:0] vld_q, vld_d;
  logic [T:0] mode_q, mode_d;
  logic [T:0] last_q, last_d;

  always_comb begin
    ready_d = 1'b1;
    vld_d   = vld_q;
    mode_d  = mode_q;
    last_d  = last_q;
    if (adv) begin
      // Bubbles shift through as invalid stages; they are not squeezed out.
      vld_d  = {vld_q[T-1:0], accept};
      mode_d = {mode_q[T-1:0], acc_mode};
      last_d = {last_q[T-1:0], s_last};
    end
  end

  // ---------------------------------------------------------------------------
  // Output / accumulate stage.
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;
  logic                 m_valid_q, m_valid_d;
  logic [ACC_WIDTH-1:0] m_sum_q, m_sum_d;
  logic                 m_ovf_q, m_ovf_d;
  logic [AW1-1:0]       acc_sum;
  logic                 beat_ovf;
  logic [ACC_WIDTH-1:0] acc_sat;

  // acc_q never exceeds the max, so one extra carry bit captures "true sum
  // above max" for this beat.
  assign acc_sum  = {1'b0, acc_q} + AW1'(count);
  assign beat_ovf = acc_sum[ACC_WIDTH];
  assign acc_sat  = beat_ovf ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];

  always_comb begin
    acc_d     = acc_q;
    sticky_d  = sticky_q;
    m_valid_d = m_valid_q;
    m_sum_d   = m_sum_q;
    m_ovf_d   = m_ovf_q;
    if (adv) begin
      m_valid_d = 1'b0;
      if (vld_q[T]) begin
        if (!mode_q[T]) begin
          // Count beat: report directly, accumulator untouched.
          m_valid_d = 1'b1;
          m_sum_d   = ACC_WIDTH'(count);
          m_ovf_d   = 1'b0;
        end else if (last_q[T]) begin
          m_valid_d = 1'b1;
          m_sum_d   = acc_sat;
          m_ovf_d   = sticky_q | beat_ovf;
          acc_d     = '0;
          sticky_d  = 1'b0;
        end else begin
          acc_d     = acc_sat;
          sticky_d  = sticky_q | beat_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      vld_q     <= '0;
      mode_q    <= '0;
      last_q    <= '0;
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_sum_q   <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      vld_q     <= vld_d;
      mode_q    <= mode_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      sticky_q  <= sticky_d;
      m_valid_q <= m_valid_d;
      m_sum_q   <= m_sum_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_sum      = m_sum_q;
  assign m_overflow = m_ovf_q;

endmodule

// File: tb/tb_bit_vector_adder_pipelined.sv
// Testbench for bit_vector_adder_pipelined.
//   dut_a : defaults (16 bits, T=4, ACC_WIDTH=16)
//   dut_c : 16 bits, T=4, ACC_WIDTH=5, same stimulus as dut_a
//   dut_b : VECTOR_SIZE=13, REG_EVERY=2 (T=2)
// Expected results are pushed to per-DUT queues when a beat is accepted and
// popped when the DUT presents a result.
module tb_bit_vector_adder_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // shared stimulus for dut_a / dut_c
  logic        acc_mode, s_valid, s_last, m_ready;
  logic [15:0] s_data;
  logic        s_ready_a, m_valid_a, m_ovf_a;
  logic [15:0] m_sum_a;
  logic        s_ready_c, m_valid_c, m_ovf_c;
  logic [4:0]  m_sum_c;

  // dut_b
  logic        acc_mode_b, s_valid_b, s_last_b, m_ready_b;
  logic [12:0] s_data_b;
  logic        s_ready_b, m_valid_b, m_ovf_b;
  logic [15:0] m_sum_b;

  bit_vector_adder_pipelined dut_a (
    .clk(clk), .rst_n(rst_n), .acc_mode(acc_mode),
    .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_sum(m_sum_a), .m_overflow(m_ovf_a)
  );

  bit_vector_adder_pipelined #(.VECTOR_SIZE(16), .REG_EVERY(1), .ACC_WIDTH(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .acc_mode(acc_mode),
    .s_valid(s_valid), .s_ready(s_ready_c), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid_c), .m_ready(m_ready), .m_sum(m_sum_c), .m_overflow(m_ovf_c)
  );

  bit_vector_adder_pipelined #(.VECTOR_SIZE(13), .REG_EVERY(2), .ACC_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .acc_mode(acc_mode_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b), .s_last(s_last_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_sum(m_sum_b), .m_overflow(m_ovf_b)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        ovf;
    logic [31:0] edge_no;
    logic        chk_lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   true_acc = 0;
  int   bp_idx   = 0;
  bit   bp_en    = 1'b0;
  bit   ready_chk = 1'b0;
  logic [3:0] bp_pat = 4'b1001;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, and the task
  // returns once combinational outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
    if (bp_en) begin
      bp_idx++;
      m_ready = bp_pat[bp_idx % 4];
    end
    #1;
  endtask

  task automatic model(input logic [15:0] d, input logic mode, input logic last, input int edge_no);
    exp_t e;
    int   pc;
    pc = $countones(d);
    e.edge_no = edge_no;
    e.chk_lat = !bp_en;
    if (!mode) begin
      e.sum = 16'(pc);
      e.ovf = 1'b0;
      q_a.push_back(e);
      q_c.push_back(e);
    end else begin
      true_acc += pc;
      if (last) begin
        e.sum = (true_acc > 65535) ? 16'hFFFF : 16'(true_acc);
        e.ovf = (true_acc > 65535);
        q_a.push_back(e);
        e.sum = (true_acc > 31) ? 16'd31 : 16'(true_acc);
        e.ovf = (true_acc > 31);
        q_c.push_back(e);
        true_acc = 0;
      end
    end
  endtask

  task automatic send(input logic [15:0] d, input logic mode, input logic last);
    int waits = 0;
    s_valid = 1'b1; s_data = d; acc_mode = mode; s_last = last;
    while (s_ready_a !== 1'b1 && waits < 40) begin
      step();
      waits++;
    end
    chk("send_accept", {31'b0, s_ready_a}, 32'd1);
    if (s_ready_a === 1'b1) model(d, mode, last, edge_cnt + 1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_b(input logic [12:0] d);
    int   waits = 0;
    exp_t e;
    s_valid_b = 1'b1; s_data_b = d;
    while (s_ready_b !== 1'b1 && waits < 40) begin
      step();
      waits++;
    end
    chk("B_accept", {31'b0, s_ready_b}, 32'd1);
    if (s_ready_b === 1'b1) begin
      e.sum = 16'($countones(d));
      e.ovf = 1'b0;
      e.edge_no = edge_cnt + 1;
      e.chk_lat = 1'b1;
      q_b.push_back(e);
    end
    step();
    s_valid_b = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && w < 60) begin
      step();
      w++;
    end
    // a few idle cycles so that any extra result shows up as spurious
    repeat (3) step();
    n_checks++;
    assert ((q_a.size() + q_b.size() + q_c.size()) == 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL drain: got %0d results still outstanding, want 0",
             q_a.size() + q_b.size() + q_c.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor, sampled on the falling edge.
  // ---------------------------------------------------------------------------
  exp_t        e_a, e_b, e_c;
  logic        stall_a = 1'b0;
  logic [15:0] held_sum_a;
  logic        held_ovf_a;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        chk("hold_sum", {16'b0, m_sum_a}, {16'b0, held_sum_a});
        chk("hold_ovf", {31'b0, m_ovf_a}, {31'b0, held_ovf_a});
        chk("hold_valid", {31'b0, m_valid_a}, 32'd1);
      end
      if (ready_chk) begin
        chk("A_s_ready_rule", {31'b0, s_ready_a}, {31'b0, !(m_valid_a && !m_ready)});
        chk("C_s_ready_rule", {31'b0, s_ready_c}, {31'b0, !(m_valid_c && !m_ready)});
      end

      if (m_valid_a === 1'b1 && m_ready === 1'b1) begin
        n_checks++;
        assert (q_a.size() != 0) n_pass++;
        else begin
          n_fail++;
          $error("FAIL A_spurious: got output sum %0d, want no output", m_sum_a);
        end
        if (q_a.size() != 0) begin
          e_a = q_a.pop_front();
          $display("A out: sum=%0d ovf=%0d (want %0d/%0d)", m_sum_a, m_ovf_a, e_a.sum, e_a.ovf);
          chk("A_sum", {16'b0, m_sum_a}, {16'b0, e_a.sum});
          chk("A_ovf", {31'b0, m_ovf_a}, {31'b0, e_a.ovf});
          if (e_a.chk_lat) chk("A_latency", edge_cnt - e_a.edge_no, 32'd5);
        end
      end

      if (m_valid_c === 1'b1 && m_ready === 1'b1) begin
        n_checks++;
        assert (q_c.size() != 0) n_pass++;
        else begin
          n_fail++;
          $error("FAIL C_spurious: got output sum %0d, want no output", m_sum_c);
        end
        if (q_c.size() != 0) begin
          e_c = q_c.pop_front();
          $display("C out: sum=%0d ovf=%0d (want %0d/%0d)", m_sum_c, m_ovf_c, e_c.sum, e_c.ovf);
          chk("C_sum", {27'b0, m_sum_c}, {16'b0, e_c.sum});
          chk("C_ovf", {31'b0, m_ovf_c}, {31'b0, e_c.ovf});
          if (e_c.chk_lat) chk("C_latency", edge_cnt - e_c.edge_no, 32'd5);
        end
      end

      if (m_valid_b === 1'b1 && m_ready_b === 1'b1) begin
        n_checks++;
        assert (q_b.size() != 0) n_pass++;
        else begin
          n_fail++;
          $error("FAIL B_spurious: got output sum %0d, want no output", m_sum_b);
        end
        if (q_b.size() != 0) begin
          e_b = q_b.pop_front();
          $display("B out: sum=%0d ovf=%0d (want %0d/%0d)", m_sum_b, m_ovf_b, e_b.sum, e_b.ovf);
          chk("B_sum", {16'b0, m_sum_b}, {16'b0, e_b.sum});
          chk("B_ovf", {31'b0, m_ovf_b}, {31'b0, e_b.ovf});
          chk("B_latency", edge_cnt - e_b.edge_no, 32'd3);
        end
      end

      stall_a    = (m_valid_a === 1'b1) && (m_ready === 1'b0);
      held_sum_a = m_sum_a;
      held_ovf_a = m_ovf_a;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] rnd;
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; acc_mode = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    s_valid_b = 1'b0; s_data_b = '0; acc_mode_b = 1'b0; s_last_b = 1'b0; m_ready_b = 1'b1;

    // reset state
    step();
    step();
    chk("rst_m_valid", {31'b0, m_valid_a}, 32'd0);
    chk("rst_m_sum", {16'b0, m_sum_a}, 32'd0);
    chk("rst_m_ovf", {31'b0, m_ovf_a}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready_a}, 32'd0);
    chk("rst_B_m_valid", {31'b0, m_valid_b}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_s_ready", {31'b0, s_ready_a}, 32'd1);
    chk("post_rst_B_s_ready", {31'b0, s_ready_b}, 32'd1);
    ready_chk = 1'b1;

    // count mode, back-to-back: 16, 0, 8
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'h0000, 1'b0, 1'b0);
    send(16'hA5A5, 1'b0, 1'b0);
    drain();

    // non-power-of-two width, T = 2: 13, 1
    send_b(13'h1FFF);
    send_b(13'h1000);
    drain();

    // count beat between accumulate beats: 8 then 17
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'h00FF, 1'b0, 1'b0);
    send(16'h0001, 1'b1, 1'b1);
    drain();

    // accumulate packet 21, then single-beat packet 2
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'h00F0, 1'b1, 1'b0);
    send(16'h0001, 1'b1, 1'b1);
    send(16'h0003, 1'b1, 1'b1);
    drain();

    // saturation: 48 in dut_a, clamps to 31 with overflow in dut_c; then 1
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'hFFFF, 1'b1, 1'b1);
    send(16'h0001, 1'b1, 1'b1);
    drain();

    // backpressure: m_ready pattern 1,0,0,1 while streaming 8 count beats
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rnd = 16'($urandom_range(0, 65535));
      send(rnd, 1'b0, 1'b0);
    end
    repeat (12) step();
    bp_en = 1'b0;
    m_ready = 1'b1;
    drain();

    // reset in the middle of a packet drops the partial total
    send(16'hFFFF, 1'b1, 1'b0);
    send(16'hFFFF, 1'b1, 1'b0);
    ready_chk = 1'b0;
    rst_n = 1'b0;
    true_acc = 0;
    step();
    chk("midrst_m_valid", {31'b0, m_valid_a}, 32'd0);
    chk("midrst_s_ready", {31'b0, s_ready_a}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("midrst_post_s_ready", {31'b0, s_ready_a}, 32'd1);
    ready_chk = 1'b1;
    send(16'h000F, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_vector_adder_pipelined.md
Name: bit_vector_adder_pipelined

Overview:
Parametrised, pipelined population-count unit. Successor to the combinational bit-vector adder tree.
- Accepts any VECTOR_SIZE ≥ 2, not only powers of two.
- Inserts register stages into the adder tree at a configurable spacing.
- Uses valid/ready handshakes with full backpressure on input and output.
- Optional accumulate mode sums popcounts across a multi-beat packet, with saturation.
- Sits between a streaming bitmap source and downstream statistics/threshold logic.

Parameters:
VECTOR_SIZE, 16, input vector width in bits; must be ≥ 2; non-power-of-two widths are zero-padded to P = 2^clog2(VECTOR_SIZE).
REG_EVERY, 1, tree levels per register stage; must be ≥ 1; L = clog2(P) tree levels; tree stages T = ceil(L/REG_EVERY).
ACC_WIDTH, 16, output/accumulator width; must be ≥ clog2(VECTOR_SIZE)+1.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
acc_mode  in  1  0 = count mode, 1 = accumulate mode; sampled per accepted beat
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid && s_ready
s_data  in  VECTOR_SIZE  bit vector to count
s_last  in  1  last beat of packet; used only in accumulate mode
m_valid  out  1  result valid
m_ready  in  1  downstream accept
m_sum  out  ACC_WIDTH  popcount (count mode) or packet total (accumulate mode)
m_overflow  out  1  packet total saturated (accumulate mode only)

Behaviour:
- Reset: all stage valids = 0, accumulator = 0, sticky overflow = 0. Outputs: m_valid = 0, m_sum = 0, m_overflow = 0. s_ready = 1 one cycle after reset deasserts.
- Reset mid-packet: all in-flight beats are dropped; the partial accumulation is discarded with no output.
- Pipeline: T tree stages plus one output/accumulate stage. Each stage carries data, valid, acc_mode and s_last.
  - Tree stage k registers the sums of levels (k−1)·REG_EVERY+1 .. k·REG_EVERY.
  - Level-n partial sums are n+1 bits wide; pad bits are constant 0.
- Flow control: global enable adv = !m_valid || m_ready. All stages advance only when adv = 1. s_ready = adv (combinational from m_valid/m_ready). Bubbles are not compressed.
- Latency: a beat accepted at edge E produces m_valid at edge E+T+1 if adv stays 1. For defaults (T = 4) that is 5 cycles. Throughput is 1 beat/cycle with m_ready held 1.
- Holding: while m_valid = 1 and m_ready = 0, m_sum and m_overflow hold stable; no state changes.
- Count mode beat: at the output stage m_sum = zero-extended popcount, m_overflow = 0, accumulator untouched, m_valid = 1. s_last is ignored.
- Accumulate mode beat, not last:
  - acc ← sat(acc + count), where sat clamps at 2^ACC_WIDTH − 1.
  - overflow_sticky |= (true sum > 2^ACC_WIDTH − 1).
  - No m_valid.
- Accumulate mode beat, last:
  - m_sum = sat(acc + count); m_overflow = overflow_sticky | this beat's overflow; m_valid = 1.
  - acc and overflow_sticky clear to 0 in the same cycle.
  - A single-beat packet (s_last on first beat) yields its own count.
- Mixed modes: a count-mode beat arriving between accumulate beats outputs normally and leaves the accumulator intact. Mode is per-beat and travels with its data.
- Illegal parameters (VECTOR_SIZE < 2, REG_EVERY < 1, ACC_WIDTH too small) are caught by an elaboration-time check.

Test Plan:
- Default params, count mode, s_data = 16'hFFFF then 16'h0000 then 16'hA5A5, m_ready = 1 -> m_valid on edges E+5, E+6, E+7 with m_sum = 16, 0, 8; m_overflow = 0.
- VECTOR_SIZE = 13, REG_EVERY = 2 (T = 2), s_data = 13'h1FFF -> m_sum = 13 at edge E+3; s_data = 13'h1000 -> 1.
- Backpressure: stream 8 beats while m_ready toggles 1,0,0,1,… -> all 8 results arrive in order, none dropped or duplicated. m_sum is stable while m_valid && !m_ready; s_ready = 0 exactly when m_valid && !m_ready.
- Accumulate: beats 16'hFFFF, 16'h00F0, 16'h0001 (s_last on the third) -> exactly one m_valid with m_sum = 21, m_overflow = 0. A following single-beat packet 16'h0003 with s_last -> 2.
- Saturation, ACC_WIDTH = 5: three accumulate beats of 16'hFFFF, last on the third -> m_sum = 31, m_overflow = 1. The next packet of 16'h0001 with last -> m_sum = 1, m_overflow = 0.
- Reset mid-packet: two accumulate beats 16'hFFFF, assert rst_n = 0 for 1 cycle, then one accumulate beat 16'h000F with last -> m_sum = 4, and no output appears for the dropped beats.
